// File: rtl/edge_event_arbiter.sv
// Per-channel rising/falling edge detector. Detected edges are latched as pending
// events and a round-robin arbiter offers them one at a time on a valid/ready port.
module edge_event_arbiter #(
   parameter int N_CH = 4,
   parameter int IDW  = $clog2(N_CH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N_CH-1:0]   x,
   input  logic [N_CH-1:0]   cfg_en,
   input  logic [2*N_CH-1:0] cfg_mode,
   output logic              evt_valid,
   input  logic              evt_ready,
   output logic [IDW-1:0]    evt_ch,
   output logic              evt_rise,
   output logic [N_CH-1:0]   ovf,
   input  logic              ovf_clr
);

   typedef enum logic {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [N_CH-1:0]   prev_x_q;
   logic [N_CH-1:0]   pending_q, pending_d;
   logic [N_CH-1:0]   pol_q, pol_d;
   logic [N_CH-1:0]   ovf_q, ovf_d;
   logic              evt_valid_q, evt_valid_d;
   logic [IDW-1:0]    evt_ch_q, evt_ch_d;
   logic              evt_rise_q, evt_rise_d;
   logic [IDW-1:0]    last_grant_q, last_grant_d;

   logic [N_CH-1:0]   rise;
   logic [N_CH-1:0]   fall;
   logic [N_CH-1:0]   qual;
   logic [N_CH-1:0]   offered;
   logic [N_CH-1:0]   grant_clr;
   logic [N_CH-1:0]   ovf_set;
   logic [N_CH-1:0]   req;
   logic              handshake;
   logic              sel_found;
   logic [IDW-1:0]    sel_idx;

   assign handshake = evt_valid_q & evt_ready;

   generate
      for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
         assign rise[gi]      = x[gi] & ~prev_x_q[gi];
         assign fall[gi]      = ~x[gi] & prev_x_q[gi];
         assign qual[gi]      = cfg_en[gi] & ((rise[gi] & cfg_mode[2*gi]) |
                                              (fall[gi] & cfg_mode[2*gi+1]));
         assign offered[gi]   = (state_q == OFFER) && (evt_ch_q == IDW'(gi));
         assign grant_clr[gi] = handshake & offered[gi];
         // A disabled channel's pending event is not offered to the consumer.
         assign req[gi]       = pending_q[gi] & cfg_en[gi];
      end
   endgenerate

   // A new edge overrides a pending event only when that event is being
   // accepted in the same cycle; otherwise the stored event is kept.
   always_comb begin
      pending_d = pending_q;
      pol_d     = pol_q;
      ovf_set   = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (qual[i] && (!pending_q[i] || grant_clr[i])) begin
            pending_d[i] = 1'b1;
            pol_d[i]     = rise[i];
         end else if (qual[i]) begin
            ovf_set[i]   = 1'b1;
         end else if (grant_clr[i]) begin
            pending_d[i] = 1'b0;
         end else if (!cfg_en[i] && !offered[i]) begin
            pending_d[i] = 1'b0;
         end
      end
      ovf_d = (ovf_q & ~{N_CH{ovf_clr}}) | ovf_set;
   end

   // Round-robin search starting just after the last granted channel.
   always_comb begin
      logic [IDW:0] probe;
      sel_found = 1'b0;
      sel_idx   = '0;
      probe     = '0;
      for (int k = 1; k <= N_CH; k++) begin
         probe = {1'b0, last_grant_q} + (IDW+1)'(k);
         if (probe >= (IDW+1)'(N_CH)) begin
            probe = probe - (IDW+1)'(N_CH);
         end
         if (!sel_found && req[probe[IDW-1:0]]) begin
            sel_found = 1'b1;
            sel_idx   = probe[IDW-1:0];
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      evt_valid_d  = evt_valid_q;
      evt_ch_d     = evt_ch_q;
      evt_rise_d   = evt_rise_q;
      last_grant_d = last_grant_q;
      case (state_q)
         IDLE: begin
            if (sel_found) begin
               state_d     = OFFER;
               evt_valid_d = 1'b1;
               evt_ch_d    = sel_idx;
               evt_rise_d  = pol_q[sel_idx];
            end else begin
               evt_valid_d = 1'b0;
            end
         end
         OFFER: begin
            if (evt_ready) begin
               state_d      = IDLE;
               evt_valid_d  = 1'b0;
               last_grant_d = evt_ch_q;
            end
         end
         default: begin
            state_d     = IDLE;
            evt_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         prev_x_q     <= '0;
         pending_q    <= '0;
         pol_q        <= '0;
         ovf_q        <= '0;
         evt_valid_q  <= 1'b0;
         evt_ch_q     <= '0;
         evt_rise_q   <= 1'b0;
         last_grant_q <= IDW'(N_CH-1);
      end else begin
         state_q      <= state_d;
         prev_x_q     <= x;
         pending_q    <= pending_d;
         pol_q        <= pol_d;
         ovf_q        <= ovf_d;
         evt_valid_q  <= evt_valid_d;
         evt_ch_q     <= evt_ch_d;
         evt_rise_q   <= evt_rise_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign evt_valid = evt_valid_q;
   assign evt_ch    = evt_ch_q;
   assign evt_rise  = evt_rise_q;
   assign ovf       = ovf_q;

endmodule

// File: doc/edge_event_arbiter.md
Name: edge_event_arbiter

Overview:
- Multi-channel controller for dual-edge detection: per-channel rising/falling detection with runtime edge selection.
- Latches detected edges as pending events and shares a single downstream event port among channels using round-robin arbitration with a valid/ready handshake.
- Sits between synchronous level inputs and an event consumer such as an interrupt or logging block.
- Flags lost events per channel.

Parameters:
- N_CH, 4, number of input channels (2..16).
- IDW, $clog2(N_CH), channel index width (derived; do not override).

Ports:
- clk  in  1  system clock, rising-edge active.
- reset  in  1  asynchronous, active-high reset.
- x  in  N_CH  level inputs, already synchronous to clk.
- cfg_en  in  N_CH  per-channel enable.
- cfg_mode  in  2*N_CH  per-channel edge select, bits [2i+1:2i]: 00 none, 01 rising, 10 falling, 11 both.
- evt_valid  out  1  event offered.
- evt_ready  in  1  consumer accepts the event.
- evt_ch  out  IDW  channel index of the offered event.
- evt_rise  out  1  polarity of the offered event: 1 rising, 0 falling.
- ovf  out  N_CH  sticky per-channel overflow (event lost).
- ovf_clr  in  1  clears all ovf bits.

Behaviour:
- Reset (async, active-high) clears:
  - x_d (previous-sample register), pending[], pol[], ovf, evt_valid, evt_ch, evt_rise; FSM goes to IDLE.
  - last_grant is set to N_CH-1, so channel 0 has first priority after reset.
- Edge detection, per channel i:
  - rise_i = x[i] & ~x_d[i]; fall_i = ~x[i] & x_d[i].
  - qual_i = cfg_en[i] & ((rise_i & mode[0]) | (fall_i & mode[1])).
  - x_d updates every cycle regardless of cfg_en.
- Pending latch: on qual_i, set pending[i] and pol[i] = rise_i.
- FSM has two states, IDLE and OFFER.
  - IDLE: if any pending bit is set, select the first pending channel searching from last_grant+1 upward with wrap-around. Register evt_ch and evt_rise = pol[ch], assert evt_valid, go to OFFER. Otherwise stay in IDLE with evt_valid=0.
  - OFFER: evt_valid, evt_ch and evt_rise are held stable while evt_ready=0. On evt_valid & evt_ready: clear pending[evt_ch], set last_grant = evt_ch, deassert evt_valid, go to IDLE.
- Throughput and latency:
  - Each grant takes at least 2 cycles, with one idle cycle between consecutive events.
  - Latency: input change sampled at clock edge k sets pending at k; evt_valid is high after edge k+1 if the port is free.
- Overflow: qual_i while pending[i]=1 and not being cleared this cycle sets ovf[i]. The stored event, including its polarity, is kept; the new event is dropped.
- Handshake on channel i in the same cycle as qual_i: the set wins. pending[i] stays 1 with the new pol, and ovf is not set.
- ovf_clr in the same cycle as a new overflow on channel i: ovf[i] ends at 1 (set wins). Other bits clear.
- cfg_en[i] deasserted:
  - Clears pending[i] next cycle, except the event currently offered, which completes normally.
  - Overflow bits are unaffected.
- cfg_mode changes take effect on the next sampled edge. Events already pending are unaffected.
- Reset asserted mid-OFFER: evt_valid drops immediately (async), and the event is discarded.

Test Plan:
- Reset/idle:
  - Reset asserted mid-OFFER -> evt_valid=0 immediately; ovf=0.
  - After release with x static -> evt_valid stays 0 for 20 cycles.
- Mode filtering:
  - ch1 mode=01, en=1, ready=1; x[1] 0→1 -> evt_valid one cycle later with evt_ch=1, evt_rise=1.
  - x[1] 1→0 -> no event.
  - mode=11 -> falling edge gives evt_rise=0.
- Simultaneous requests: all 4 channels mode=01, rising together, ready=1 -> grants ch0,1,2,3 in order, each evt_valid high 1 cycle, separated by 1 low cycle; pending all 0 afterwards.
- Round-robin fairness:
  - ch0 mode=11 toggling every 2 cycles; ch2 single rising edge.
  - ch2 granted immediately after at most one ch0 grant; ch0 then granted next.
- Backpressure and overflow:
  - ready=0; ch3 rises then falls.
  - evt_ch=3 and evt_rise=1 held stable for 6 cycles; ovf[3]=1.
  - ready=1 -> event accepted, no second event.
  - ovf_clr -> ovf=0.
- Set-wins corner:
  - ch2 rising event offered; ch2 falls in the handshake cycle.
  - After one idle cycle, re-offered with evt_ch=2, evt_rise=0; ovf[2]=0.
